apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: ACCESS-phase cycles without PREADY before forced error completion.
REQ-002 SHALL have one clock and a synchronous, active-high reset: PCLK (in, 1, clock); PRESET (in, 1, synchronous active-high reset).
REQ-003 SHALL have CPU side: transfer (in, 1, start request); write (in, 1, 1=write); addr (in, 32, byte address); wdata (in, 32, write data); rdata (out, 32, read data); ready (out, 1, completion pulse); error (out, 1, failed completion, valid with ready).
REQ-004 SHALL have shared APB outputs: PADDR (out, 32); PWRITE (out, 1); PENABLE (out, 1); PWDATA (out, 32).
REQ-005 SHALL have PSEL0..PSEL4 (out, 1 each, slave selects), PRDATA0..PRDATA4 (in, 32 each) and PREADY0..PREADY4 (in, 1 each).

Function
REQ-006 SHALL decode addr[31:12]: 0x10000 slave0 (RAM), 0x10001 slave1 (GPO), 0x10002 slave2 (GPI), 0x10003 slave3 (GPIO), 0x10004 slave4 (UART); all other values are unmapped.
REQ-007 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-008 IDLE: transfer=1 at a clock edge SHALL latch addr, write and wdata into PADDR, PWRITE and PWDATA and go to SETUP; transfer=0 SHALL stay in IDLE.
REQ-009 SETUP: selected PSELx=1, PENABLE=0; SHALL go unconditionally to ACCESS at the next edge.
REQ-010 ACCESS: selected PSELx=1, PENABLE=1; SHALL stay in ACCESS while the selected PREADYx=0 and the timeout has not expired.
REQ-011 ACCESS with selected PREADYx=1: ready=1 and error=0 combinationally in that cycle; rdata=PRDATAx for reads, 0 for writes; next state IDLE.
REQ-012 At most one PSELx SHALL be high at any time; all PSELx SHALL be 0 in IDLE and for unmapped addresses.
REQ-013 Unmapped address: SHALL run SETUP then ACCESS with no PSEL, completing in the first ACCESS cycle with ready=1, error=1, rdata=0.
REQ-014 Timeout: a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without PREADY; at count=TIMEOUT_CYCLES-1 with PREADY still 0 it SHALL give ready=1, error=1, rdata=0 and return to IDLE.
REQ-015 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the last ACCESS cycle, and SHALL hold their last values in IDLE.
REQ-016 ready and error SHALL be 0 in all states except the completing ACCESS cycle; ready SHALL be exactly one cycle wide per transfer.
REQ-017 transfer asserted in SETUP or ACCESS SHALL be ignored, with no queuing.
REQ-018 Minimum latency: transfer sampled at edge k gives SETUP in cycle k+1, ACCESS in k+2, and earliest ready in k+2; a slave with registered PREADY gives ready in k+3.
REQ-019 Back-to-back: transfer=1 in the IDLE cycle after a completion SHALL start the next transaction with no extra idle cycle.
REQ-020 PREADY and PRDATA of unselected slaves SHALL be ignored.

Reset
REQ-021 PRESET=1 at a clock edge SHALL set state=IDLE, PSEL0..4=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0 and timeout counter=0; ready, error and rdata SHALL then be 0.
REQ-022 Reset mid-transaction SHALL abort the transaction with no ready pulse; the slave sees PSEL and PENABLE drop at that edge.
REQ-023 Reset SHALL take priority over transfer in the same cycle.

Verification
REQ-024 After reset, write 0x1000_1004 <- 0x0000_00A5, slave1 PREADY one cycle after PENABLE -> PSEL1 high for 3 cycles, PENABLE high for 2 cycles, ready=1 and error=0 in cycle k+3, PADDR=0x1000_1004 and PWDATA=0xA5 stable throughout.
REQ-025 Read 0x1000_1000, slave1 PRDATA=0x0000_00FF with PREADY in the first ACCESS cycle -> ready in k+2, rdata=0x0000_00FF, PWRITE=0.
REQ-026 Read 0x2000_0000 -> no PSEL ever high, ready=1, error=1, rdata=0 in cycle k+2.
REQ-027 Write to slave3 with PREADY3 held 0 -> ready=1 and error=1 after exactly 16 ACCESS cycles, FSM back in IDLE.
REQ-028 Two back-to-back transfers (slave0 write, then slave4 read) -> second SETUP immediately follows first completion; PRESET pulsed during the second ACCESS -> no ready, all outputs at reset values.

Source files
------------

// File: rtl/apb_master.sv
// APB master bridging a simple CPU request port to five APB slaves.
//
// A request is taken in IDLE when transfer=1. It then runs one SETUP cycle
// and one or more ACCESS cycles. The transfer completes with a single-cycle
// ready pulse, and error marks an unmapped address or a timeout. Slave
// selection comes from addr[31:12]. Pages 0x10000..0x10004 map to slaves 0..4.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   transfer, write       start request and direction (1 = write), sampled in IDLE
//   addr, wdata           byte address and write data, latched when a request starts
//   rdata, ready, error   completion data, completion pulse, failed-completion flag
//   PADDR, PWRITE,
//   PENABLE, PWDATA       APB signals shared by all slaves
//   PSEL0..4              per-slave selects (at most one high)
//   PRDATA0..4, PREADY0..4 per-slave read data and ready
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  output logic        PSEL4,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic [31:0] PRDATA4,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3,
  input  logic        PREADY4
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_t;

  state_t          state_q;
  logic [4:0]      sel_q;
  logic [CntW-1:0] tmo_cnt_q;

  logic [4:0]  dec_sel;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        in_access;
  logic        done_ok;
  logic        done_err;

  // Decode the incoming address. The result is latched with the request, so
  // the select stays steady even while the CPU changes addr.
  always_comb begin
    dec_sel = 5'b00000;
    unique case (addr[31:12])
      20'h10000: dec_sel = 5'b00001;
      20'h10001: dec_sel = 5'b00010;
      20'h10002: dec_sel = 5'b00100;
      20'h10003: dec_sel = 5'b01000;
      20'h10004: dec_sel = 5'b10000;
      default:   dec_sel = 5'b00000;
    endcase
  end

  // Only the selected slave's PREADY and PRDATA are used.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    unique case (sel_q)
      5'b00001: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
      5'b00010: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
      5'b00100: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
      5'b01000: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
      5'b10000: begin sel_ready = PREADY4; sel_rdata = PRDATA4; end
      default: ;
    endcase
  end

  assign in_access = (state_q == StAccess);
  assign done_ok   = in_access && sel_ready;
  // An unmapped address fails in its first ACCESS cycle. A mapped one fails
  // on the last allowed cycle if the slave is still not ready.
  assign done_err  = in_access && !sel_ready && ((sel_q == 5'b00000) || (tmo_cnt_q == CntLast));

  assign ready = done_ok || done_err;
  assign error = done_err;
  assign rdata = (done_ok && !PWRITE) ? sel_rdata : 32'h0;

  assign PSEL0 = sel_q[0];
  assign PSEL1 = sel_q[1];
  assign PSEL2 = sel_q[2];
  assign PSEL3 = sel_q[3];
  assign PSEL4 = sel_q[4];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      tmo_cnt_q <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PENABLE   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (transfer) begin
            PADDR   <= addr;
            PWRITE  <= write;
            PWDATA  <= wdata;
            sel_q   <= dec_sel;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          PENABLE   <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (ready) begin
            // The address, direction and write data keep their last values in IDLE.
            sel_q     <= '0;
            PENABLE   <= 1'b0;
            tmo_cnt_q <= '0;
            state_q   <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: begin
          sel_q   <= '0;
          PENABLE <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master. Each transaction is planned in advance
// as a timeline: one IDLE request cycle, one SETUP cycle, then ACCESS cycles
// up to a completion index worked out from the slave wait and the timeout.
// The bench drives the slave responses from that plan, so expectations never
// depend on what the DUT outputs.
module tb_apb_master;

  localparam int T = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer, write;
  logic [31:0] addr, wdata, rdata;
  logic        ready, error;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PENABLE;
  logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
  logic [31:0] prdata [5];
  logic [4:0]  pready;
  logic [4:0]  psel_v;

  assign psel_v = {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};

  always #5 PCLK = ~PCLK;

  apb_master #(.TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .error(error),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4),
    .PRDATA0(prdata[0]), .PRDATA1(prdata[1]), .PRDATA2(prdata[2]),
    .PRDATA3(prdata[3]), .PRDATA4(prdata[4]),
    .PREADY0(pready[0]), .PREADY1(pready[1]), .PREADY2(pready[2]),
    .PREADY3(pready[3]), .PREADY4(pready[4])
  );

  int checks = 0;
  int passes = 0;

  // Expected outputs for the current cycle.
  bit          exp_valid;
  logic [4:0]  exp_sel;
  logic        exp_penable, exp_pwrite, exp_ready, exp_error;
  logic [31:0] exp_paddr, exp_pwdata, exp_rdata;

  // Model of the last latched request; these values hold through IDLE.
  logic [31:0] m_paddr, m_pwdata;
  logic        m_pwrite;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge PCLK) begin
    #2;
    if (exp_valid) begin
      chk("psel", 32'(psel_v), 32'(exp_sel));
      chk("penable", 32'(PENABLE), 32'(exp_penable));
      chk("paddr", PADDR, exp_paddr);
      chk("pwrite", 32'(PWRITE), 32'(exp_pwrite));
      chk("pwdata", PWDATA, exp_pwdata);
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("error", 32'(error), 32'(exp_error));
      chk("rdata", rdata, exp_rdata);
    end
  end

  function automatic logic [4:0] dec(input logic [31:0] a);
    int unsigned page = 32'(a[31:12]);
    if (page >= 32'h10000 && page <= 32'h10004) return 5'(1 << (page - 32'h10000));
    return 5'b0;
  endfunction

  function automatic int slave_idx(input logic [31:0] a);
    return int'(a[31:12]) - 32'h10000;
  endfunction

  function void set_idle_exp();
    exp_valid   = 1'b1;
    exp_sel     = '0;
    exp_penable = 1'b0;
    exp_paddr   = m_paddr;
    exp_pwrite  = m_pwrite;
    exp_pwdata  = m_pwdata;
    exp_ready   = 1'b0;
    exp_error   = 1'b0;
    exp_rdata   = '0;
  endfunction

  task automatic randomize_slaves();
    for (int i = 0; i < 5; i++) begin
      prdata[i] = $urandom;
      pready[i] = 1'($urandom);
    end
  endtask

  task automatic idle_cycle();
    @(negedge PCLK);
    PRESET   = 1'b0;
    transfer = 1'b0;
    write    = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    randomize_slaves();
    set_idle_exp();
  endtask

  // wt: ACCESS cycles before the slave answers (-1 = never).
  // rst_at: ACCESS cycle in which PRESET is raised (-1 = none).
  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int wt, input int rst_at,
                        output int n_sel, output int n_en, output int ready_off,
                        output bit err_seen, output logic [31:0] rd_seen);
    logic [4:0] sel;
    bit unm, exp_err, done, rst_now;
    int m, idx;
    sel = dec(a);
    unm = (sel == 5'b0);
    idx = unm ? 0 : slave_idx(a);
    if (unm) begin m = 0; exp_err = 1'b1; end
    else if (wt >= 0 && wt <= T - 1) begin m = wt; exp_err = 1'b0; end
    else begin m = T - 1; exp_err = 1'b1; end
    n_sel = 0; n_en = 0; ready_off = -1; err_seen = 1'b0; rd_seen = '0;

    // Request cycle, still in IDLE.
    @(negedge PCLK);
    PRESET = 1'b0; transfer = 1'b1; write = wr; addr = a; wdata = wd;
    randomize_slaves();
    set_idle_exp();
    #3;
    n_sel += (psel_v != 0) ? 1 : 0;
    m_paddr = a; m_pwrite = wr; m_pwdata = wd;

    for (int c = 1; c <= m + 2; c++) begin
      @(negedge PCLK);
      // Requests made while busy must be dropped.
      transfer = 1'($urandom); write = 1'($urandom); addr = $urandom; wdata = $urandom;
      randomize_slaves();
      if (!unm) begin
        prdata[idx] = rd;
        if (c >= 2) pready[idx] = (c - 2 == wt);
      end
      rst_now = (rst_at >= 0) && (c == 2 + rst_at);
      if (rst_now) begin PRESET = 1'b1; transfer = 1'b1; end
      done = (c == m + 2) && !rst_now;
      exp_valid   = 1'b1;
      exp_sel     = sel;
      exp_penable = (c >= 2);
      exp_paddr   = a;
      exp_pwrite  = wr;
      exp_pwdata  = wd;
      exp_ready   = done;
      exp_error   = done && exp_err;
      exp_rdata   = (done && !exp_err && !wr) ? rd : 32'h0;
      #3;
      n_sel += (psel_v != 0) ? 1 : 0;
      n_en  += PENABLE ? 1 : 0;
      if (ready && ready_off < 0) begin ready_off = c; err_seen = error; rd_seen = rdata; end
      if (rst_now) begin
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
        break;
      end
    end
  endtask

  int n_sel, n_en, roff;
  bit esn;
  logic [31:0] rds;

  initial begin
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 5; i++) begin prdata[i] = '0; pready[i] = 1'b0; end
    exp_valid = 1'b0;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;

    // Reset held while transfer is requested; reset must win.
    @(negedge PCLK);
    PRESET = 1'b1; transfer = 1'b1; addr = 32'h1000_0000; wdata = 32'hDEAD_BEEF; write = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1; transfer = 1'b1;
    set_idle_exp();
    #3;
    chk("reset_paddr", PADDR, 32'h0);
    chk("reset_psel", 32'(psel_v), 32'h0);
    idle_cycle();
    idle_cycle();

    // Write to slave1, PREADY one cycle after PENABLE.
    do_txn(1'b1, 32'h1000_1004, 32'h0000_00A5, 32'h0, 1, -1, n_sel, n_en, roff, esn, rds);
    chk("w_slave1_psel_cycles", 32'(n_sel), 32'd3);
    chk("w_slave1_penable_cycles", 32'(n_en), 32'd2);
    chk("w_slave1_ready_cycle", 32'(roff), 32'd3);
    chk("w_slave1_error", 32'(esn), 32'd0);
    idle_cycle();

    // Read from slave1 with PREADY in the first ACCESS cycle.
    do_txn(1'b0, 32'h1000_1000, 32'h1234_5678, 32'h0000_00FF, 0, -1, n_sel, n_en, roff, esn, rds);
    chk("r_slave1_ready_cycle", 32'(roff), 32'd2);
    chk("r_slave1_rdata", rds, 32'h0000_00FF);
    idle_cycle();

    // Unmapped read.
    do_txn(1'b0, 32'h2000_0000, 32'h0, 32'h5555_5555, 0, -1, n_sel, n_en, roff, esn, rds);
    chk("unmapped_psel_cycles", 32'(n_sel), 32'd0);
    chk("unmapped_ready_cycle", 32'(roff), 32'd2);
    chk("unmapped_error", 32'(esn), 32'd1);
    chk("unmapped_rdata", rds, 32'h0);
    idle_cycle();

    // Timeout on slave3.
    do_txn(1'b1, 32'h1000_3010, 32'hCAFE_F00D, 32'h0, -1, -1, n_sel, n_en, roff, esn, rds);
    chk("timeout_access_cycles", 32'(n_en), 32'd16);
    chk("timeout_ready_cycle", 32'(roff), 32'd17);
    chk("timeout_error", 32'(esn), 32'd1);
    idle_cycle();

    // Back-to-back: slave0 write, then slave4 read reset in its second ACCESS cycle.
    do_txn(1'b1, 32'h1000_0020, 32'h0BAD_F00D, 32'h0, 2, -1, n_sel, n_en, roff, esn, rds);
    chk("b2b_first_ready_cycle", 32'(roff), 32'd4);
    do_txn(1'b0, 32'h1000_4000, 32'h0, 32'h7777_7777, -1, 1, n_sel, n_en, roff, esn, rds);
    chk("b2b_reset_no_ready", 32'(roff), 32'hFFFF_FFFF);
    chk("b2b_reset_psel_cycles", 32'(n_sel), 32'd3);
    idle_cycle();
    #3;
    chk("after_reset_paddr", PADDR, 32'h0);
    chk("after_reset_penable", 32'(PENABLE), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int s, wt, ra, r;
      logic [31:0] a;
      s  = $urandom_range(0, 5);
      ra = -1;
      if (s == 5) begin a = $urandom; a[31] = 1'b1; end
      else a = {20'h10000 + 20'(s), 12'($urandom)};
      r = $urandom_range(0, 9);
      if (r <= 5) wt = $urandom_range(0, 3);
      else if (r == 6) wt = T - 1;
      else if (r == 7) wt = T;
      else if (r == 8) wt = -1;
      else wt = $urandom_range(4, T - 2);
      if (s != 5 && $urandom_range(0, 19) == 0) begin wt = -1; ra = $urandom_range(0, T - 2); end
      do_txn(1'($urandom), a, $urandom, $urandom, wt, ra, n_sel, n_en, roff, esn, rds);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
    @(negedge PCLK);
    exp_valid = 1'b0;
    #4;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
